// File: rtl/intpol2_d4_pkg.sv
// Shared definitions for the quadratic-interpolation sequencing controller.
//   state_t  : controller state encoding
//   XI2_*    : sel_xi2 codes (first point of a segment / subsequent step)
//   strb_t   : registered strobe bundle driven toward the datapath
//   decode() : strobe pattern for a given state
package intpol2_d4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD0 = 4'd1,
    ST_LOAD1 = 4'd2,
    ST_LOAD2 = 4'd3,
    ST_COEF  = 4'd4,
    ST_MUL1  = 4'd5,
    ST_MUL2  = 4'd6,
    ST_OUT   = 4'd7,
    ST_NEXT  = 4'd8,
    ST_FIN   = 4'd9
  } state_t;

  localparam logic [1:0] XI2_FIRST = 2'b00;
  localparam logic [1:0] XI2_STEP  = 2'b01;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       in_ready;
    logic       out_valid;
    logic       op_1;
    logic       clear;
    logic       sel_mult;
    logic       ld_p1_xi;
    logic       en_sum;
    logic       ld_data;
    logic [1:0] sel_xi2;
  } strb_t;

  // first_pt: point counter is zero, i.e. xi^2 restarts from its cleared value.
  function automatic strb_t decode(input state_t s, input logic first_pt);
    strb_t o;
    o = '0;
    case (s)
      ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_NEXT: begin
        o.busy     = 1'b1;
        o.in_ready = 1'b1;
      end
      ST_COEF: begin
        o.busy  = 1'b1;
        o.op_1  = 1'b1;
        o.clear = 1'b1;
      end
      ST_MUL1: begin
        o.busy     = 1'b1;
        o.ld_p1_xi = 1'b1;
      end
      ST_MUL2: begin
        o.busy     = 1'b1;
        o.sel_mult = 1'b1;
        o.ld_data  = 1'b1;
        o.en_sum   = 1'b1;
        o.sel_xi2  = first_pt ? XI2_FIRST : XI2_STEP;
      end
      ST_OUT: begin
        o.busy      = 1'b1;
        o.out_valid = 1'b1;
      end
      ST_FIN:  o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/intpol2_d4_counter.sv
// Up-counter with synchronous clear (priority) and enable.
//   clk, rstn : clock, async active-low reset
//   clr, en   : clear to zero / increment by one
//   q         : count value
module intpol2_d4_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + W'(1);
  end

endmodule

// File: rtl/intpol2_d4_control.sv
// Sequencing controller for the quadratic-interpolation datapath.
// Loads a three-sample window, latches coefficients once per segment and
// steps n_points outputs per segment, with valid/ready on both sides.
//   clk, rstn            : clock, async active-low reset
//   start, n_samples,
//   n_points, busy, done : job control
//   in_valid / in_ready  : sample input handshake
//   out_valid / out_ready: point output handshake
//   Ld_M0..sel_xi2       : datapath strobes
module intpol2_d4_control
  import intpol2_d4_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int L_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [L_W-1:0]   n_points,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Ld_M0,
  output logic             Ld_M1,
  output logic             Ld_M2,
  output logic             en_stream,
  output logic             op_1,
  output logic             clear,
  output logic             sel_mult,
  output logic             Ld_p1_xi,
  output logic             en_sum,
  output logic             Ld_data,
  output logic [1:0]       sel_xi2
);

  state_t           state, state_nxt;
  strb_t            strb;
  logic [CNT_W-1:0] ns_q, smp_cnt;
  logic [L_W-1:0]   np_q, pt_cnt;
  logic             in_hs, out_hs, more_pts, more_smp, cfg_bad, job_go;

  assign job_go   = (state == ST_IDLE) && start;
  assign in_hs    = in_valid & strb.in_ready;
  assign out_hs   = strb.out_valid & out_ready;
  // One extra bit so pt_cnt + 1 cannot wrap when n_points is all ones.
  assign more_pts = ((L_W+1)'(pt_cnt) + (L_W+1)'(1)) < (L_W+1)'(np_q);
  assign more_smp = smp_cnt < ns_q;
  assign cfg_bad  = (n_samples < CNT_W'(3)) || (n_points == '0);

  // Samples accepted this job (window loads and per-segment refills).
  intpol2_d4_counter #(.W(CNT_W)) u_smp_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (job_go),
    .en  (in_hs),
    .q   (smp_cnt)
  );

  // Point index i within the current segment.
  intpol2_d4_counter #(.W(L_W)) u_pt_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (state == ST_COEF),
    .en  (out_hs),
    .q   (pt_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = cfg_bad ? ST_FIN : ST_LOAD0;
      ST_LOAD0: if (in_valid) state_nxt = ST_LOAD1;
      ST_LOAD1: if (in_valid) state_nxt = ST_LOAD2;
      ST_LOAD2: if (in_valid) state_nxt = ST_COEF;
      ST_COEF:  state_nxt = ST_MUL1;
      ST_MUL1:  state_nxt = ST_MUL2;
      ST_MUL2:  state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = more_pts ? ST_MUL1 :
                                           more_smp ? ST_NEXT : ST_FIN;
      ST_NEXT:  if (in_valid) state_nxt = ST_COEF;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is a clean
  // flop output aligned with the state it belongs to. pt_cnt does not
  // move in MUL1, so its value here is the i seen during MUL2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      strb  <= '0;
      ns_q  <= '0;
      np_q  <= '0;
    end else begin
      state <= state_nxt;
      strb  <= decode(state_nxt, pt_cnt == '0);
      if (job_go) begin
        ns_q <= n_samples;
        np_q <= n_points;
      end
    end
  end

  // Window loads must fire in the handshake cycle, while the sample is
  // still on the bus, so these are qualified combinationally.
  assign Ld_M0     = in_hs && (state == ST_LOAD0);
  assign Ld_M1     = in_hs && (state == ST_LOAD1);
  assign Ld_M2     = in_hs && (state == ST_LOAD2);
  assign en_stream = in_hs && (state == ST_NEXT);

  assign busy      = strb.busy;
  assign done      = strb.done;
  assign in_ready  = strb.in_ready;
  assign out_valid = strb.out_valid;
  assign op_1      = strb.op_1;
  assign clear     = strb.clear;
  assign sel_mult  = strb.sel_mult;
  assign Ld_p1_xi  = strb.ld_p1_xi;
  assign en_sum    = strb.en_sum;
  assign Ld_data   = strb.ld_data;
  assign sel_xi2   = strb.sel_xi2;

endmodule

// File: tb/tb_intpol2_d4_control.sv
module tb_intpol2_d4_control;
  localparam int CNT_W = 16;
  localparam int L_W   = 8;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic [L_W-1:0]   n_points = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic busy, done, in_ready, out_valid;
  logic Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, clear, sel_mult, Ld_p1_xi, en_sum, Ld_data;
  logic [1:0] sel_xi2;

  intpol2_d4_control #(.CNT_W(CNT_W), .L_W(L_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .n_samples(n_samples), .n_points(n_points),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .Ld_M0(Ld_M0), .Ld_M1(Ld_M1),
    .Ld_M2(Ld_M2), .en_stream(en_stream), .op_1(op_1), .clear(clear),
    .sel_mult(sel_mult), .Ld_p1_xi(Ld_p1_xi), .en_sum(en_sum), .Ld_data(Ld_data),
    .sel_xi2(sel_xi2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: job progress as "samples still needed", "point and
  // phase within point" and a coefficient-cycle flag.
  bit m_act = 0, m_fin = 0, m_init = 0, m_coef = 0;
  int m_need = 0, m_ph = -1, m_pt = 0, m_cons = 0, m_ns = 0, m_np = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act = 0; m_fin = 0; m_init = 0; m_coef = 0;
      m_need = 0; m_ph = -1; m_pt = 0; m_cons = 0; m_ns = 0; m_np = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_act) begin
      if (start) begin
        m_ns = int'(n_samples); m_np = int'(n_points);
        if (m_ns < 3 || m_np == 0) m_fin = 1;
        else begin m_act = 1; m_need = 3; m_init = 1; m_cons = 0; end
      end
    end else if (m_need > 0) begin
      if (in_valid) begin
        m_cons++; m_need--;
        if (m_need == 0) m_coef = 1;
      end
    end else if (m_coef) begin
      m_coef = 0; m_pt = 0; m_ph = 0;
    end else if (m_ph == 0) m_ph = 1;
    else if (m_ph == 1) m_ph = 2;
    else if (m_ph == 2 && out_ready) begin
      if (m_pt + 1 < m_np) begin m_pt++; m_ph = 0; end
      else begin
        m_ph = -1;
        if (m_cons < m_ns) begin m_need = 1; m_init = 0; end
        else begin m_act = 0; m_fin = 1; end
      end
    end
  end

  int checks = 0, passed = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Stimulus policies and per-job tallies.
  int stall_pt = 0, stall_len = 0, stall_cnt = 0, starve_len = 0, starve_cnt = 0;
  int hs, n_es, n_op, n_clr, n_x0, n_done, done_cyc, first_busy, first_ov, ov_cyc, ir_cyc, busy_cyc;
  int hs_cyc[$];
  int start_edge;

  task automatic clr_tally();
    hs = 0; n_es = 0; n_op = 0; n_clr = 0; n_x0 = 0; n_done = 0; done_cyc = -1;
    first_busy = -1; first_ov = -1; ov_cyc = 0; ir_cyc = 0; busy_cyc = 0;
    hs_cyc.delete(); stall_cnt = 0; starve_cnt = 0;
  endtask

  function automatic logic [15:0] got_vec();
    return {busy, done, in_ready, out_valid, Ld_M0, Ld_M1, Ld_M2, en_stream,
            op_1, clear, sel_mult, Ld_p1_xi, en_sum, Ld_data, sel_xi2};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic ir, ld, p0, p1;
    ir = m_act && (m_need > 0);
    ld = ir && in_valid;
    p0 = (m_ph == 0);
    p1 = (m_ph == 1);
    return {m_act, m_fin, ir, (m_ph == 2),
            ld && m_init && (m_need == 3), ld && m_init && (m_need == 2),
            ld && m_init && (m_need == 1), ld && !m_init,
            m_coef, m_coef, p1, p0, p1, p1,
            (p1 && m_pt != 0) ? 2'b01 : 2'b00};
  endfunction

  // One cycle: drive reactive inputs on the falling edge, then compare.
  task automatic step();
    logic [15:0] g, e;
    @(negedge clk);
    if (out_valid && hs + 1 == stall_pt && stall_cnt < stall_len) begin
      out_ready = 1'b0; stall_cnt++;
    end else out_ready = 1'b1;
    if (in_ready && hs > 0 && starve_cnt < starve_len) begin
      in_valid = 1'b0; starve_cnt++;
    end else in_valid = 1'b1;
    #1;
    g = got_vec(); e = exp_vec();
    checks++;
    if (g === e) passed++;
    else $display("FAIL cycle_vec @%0d: got %b expected %b", cyc, g, e);
    if (out_valid && out_ready) begin hs++; hs_cyc.push_back(cyc); end
    if (en_stream) n_es++;
    if (op_1) n_op++;
    if (clear) n_clr++;
    if (Ld_data && sel_xi2 == 2'b00) n_x0++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) begin busy_cyc++; if (first_busy < 0) first_busy = cyc; end
    if (out_valid) begin ov_cyc++; if (first_ov < 0) first_ov = cyc; end
    if (in_ready) ir_cyc++;
  endtask

  task automatic run_job(input int ns, input int np);
    clr_tally();
    n_samples = CNT_W'(ns); n_points = L_W'(np);
    start = 1'b1; start_edge = cyc;
    step();
    start = 1'b0;  // held through one busy cycle: must be ignored
    for (int k = 0; k < 400 && n_done == 0; k++) step();
    if (n_done == 0) chk("job_timeout", 0, 1);
    step();
  endtask

  initial begin #500000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  initial begin
    // Reset state.
    step(); step();
    chk("reset_outputs", int'(got_vec()), 0);
    rstn = 1'b1;
    step();

    // Single segment, 4 points.
    run_job(3, 4);
    chk("A_handshakes", hs, 4);
    for (int i = 0; i + 1 < hs_cyc.size(); i++) chk("A_hs_gap", hs_cyc[i+1] - hs_cyc[i], 3);
    chk("A_xi2_first_cnt", n_x0, 1);
    chk("A_done_after_hs", done_cyc - hs_cyc[hs_cyc.size()-1], 1);
    chk("A_first_ov_vs_busy", first_ov - first_busy, 6);
    chk("A_first_ov_vs_start", first_ov - start_edge, 7);
    chk("A_done_pulses", n_done, 1);

    // Multi-segment.
    run_job(6, 2);
    chk("B_handshakes", hs, 8);
    chk("B_en_stream", n_es, 3);
    chk("B_op_1", n_op, 4);
    chk("B_clear", n_clr, 4);
    chk("B_xi2_first_cnt", n_x0, 4);

    // Backpressure: hold off point 2 for 5 cycles.
    stall_pt = 2; stall_len = 5;
    run_job(3, 4);
    chk("C_handshakes", hs, 4);
    chk("C_ov_cycles", ov_cyc, 9);
    chk("C_stalled_gap", hs_cyc[1] - hs_cyc[0], 8);
    chk("C_done_latency", done_cyc - start_edge, 22);
    stall_pt = 0; stall_len = 0;

    // Input starvation in NEXT for 7 cycles.
    starve_len = 7;
    run_job(4, 2);
    chk("D_handshakes", hs, 4);
    chk("D_in_ready_cycles", ir_cyc, 11);
    chk("D_en_stream", n_es, 1);
    starve_len = 0;

    // Degenerate jobs.
    run_job(2, 4);
    chk("E_in_ready_cycles", ir_cyc, 0);
    chk("E_out_valid_cycles", ov_cyc, 0);
    chk("E_busy_cycles", busy_cyc, 0);
    chk("E_done_latency", done_cyc - start_edge, 1);
    run_job(5, 0);
    chk("F_out_valid_cycles", ov_cyc, 0);
    chk("F_done_latency", done_cyc - start_edge, 1);

    // Reset in MUL2 aborts the job.
    clr_tally();
    n_samples = CNT_W'(5); n_points = L_W'(4);
    start = 1'b1; start_edge = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 50 && !Ld_data; k++) step();
    chk("G_reached_mul2", int'(Ld_data), 1);
    rstn = 1'b0;
    step();
    chk("G_reset_outputs", int'(got_vec()), 0);
    step(); step();
    chk("G_no_done", n_done, 0);
    rstn = 1'b1;
    step();

    // Controller usable again after the abort.
    run_job(3, 1);
    chk("H_handshakes", hs, 1);
    chk("H_done_pulses", n_done, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
